cpu_bus_arbiter: RTL

Two-master arbiter sharing the single data port of the CPU RAM/peripheral bus (data RAM, switch/LED/digit registers) between the CPU load/store path (master 0) and a DMA/UART engine (master 1). It grants one single-beat access per cycle, supports short locked bursts, and raises a stall toward the CPU PC/register-write path while the CPU waits. It sits between the ALU-address/DataBusB side of the datapath and the RAM.

---
 rtl/cpu_bus_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/cpu_bus_arbiter.sv
// Two-master arbiter for the CPU RAM/peripheral data port: single-beat grants,
// short locked bursts capped while the other master waits, and a CPU stall.
module cpu_bus_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              cpu_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned     CntW   = $clog2(MAX_BURST);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST - 1);

    typedef enum logic [1:0] {StIdle, StG0, StG1} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   beat_q, beat_d;
    logic              last_q, last_d;   // 0: m0 owned last, 1: m1 owned last
    logic              rvalid0_q, rvalid1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic [CntW-1:0]   beat_inc;

    assign beat_inc = (beat_q == CntMax) ? beat_q : beat_q + CntW'(1);

    always_comb begin
        state_d = StIdle;
        beat_d  = '0;
        unique case (state_q)
            StIdle: begin
                if (m0_req && m1_req) state_d = last_q ? StG0 : StG1;
                else if (m0_req)      state_d = StG0;
                else if (m1_req)      state_d = StG1;
            end
            StG0: begin
                if (m0_req && m0_lock && (!m1_req || beat_q < CntMax)) begin
                    state_d = StG0;
                    beat_d  = beat_inc;
                end else if (m1_req) begin
                    state_d = StG1;
                end else if (m0_req) begin
                    state_d = StG0;
                end
            end
            StG1: begin
                if (m1_req && m1_lock && (!m0_req || beat_q < CntMax)) begin
                    state_d = StG1;
                    beat_d  = beat_inc;
                end else if (m0_req) begin
                    state_d = StG0;
                end else if (m1_req) begin
                    state_d = StG1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (state_d == StG0) last_d = 1'b0;
        if (state_d == StG1) last_d = 1'b1;
    end

    always_comb begin
        m0_gnt    = (state_q == StG0);
        m1_gnt    = (state_q == StG1);
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        if (m0_gnt && m0_req) begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_rd    = !m0_wr;
            mem_wr    = m0_wr;
        end else if (m1_gnt && m1_req) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_rd    = !m1_wr;
            mem_wr    = m1_wr;
        end
        cpu_stall = m0_req && !m0_gnt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            beat_q    <= '0;
            last_q    <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            last_q    <= last_d;
            rvalid0_q <= m0_gnt && m0_req && !m0_wr;
            rvalid1_q <= m1_gnt && m1_req && !m1_wr;
            if (m0_gnt && m0_req && !m0_wr) rdata0_q <= mem_rdata;
            if (m1_gnt && m1_req && !m1_wr) rdata1_q <= mem_rdata;
        end
    end

    assign m0_rvalid = rvalid0_q;
    assign m1_rvalid = rvalid1_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule
